lsu_wb: RTL and testbench
=========================

Name: lsu_wb

Overview:
Registered, parametrised load/store unit that bridges the core datapath to a Wishbone B4 classic master port.
- Adds over the previous combinational LSU:
  - loads as well as stores;
  - byte-lane steering from the address offset;
  - load sign/zero extension;
  - misalignment and illegal-funct3 detection;
  - registered bus outputs.
- Sits between the execute stage and the data-side Wishbone interconnect; stalls the pipeline while an access is in flight.

Parameters:
DATA_W, 32, bus/data width; legal values 32 or 64.
ADDR_W, 32, address width.
SEL_W, DATA_W/8, byte-select width (derived; not overridable).
TIMEOUT_CYC, 255, bus watchdog limit in cycles (used only with LSU_TIMEOUT_EN).

Ports:
clk_i  in  1  single clock.
rst_i  in  1  asynchronous, active-high reset.
req_i  in  1  load/store instruction present in stage.
we_i  in  1  1=store, 0=load.
funct3_i  in  3  RISC-V width/sign code.
addr_i  in  ADDR_W  effective byte address.
wdata_i  in  DATA_W  store data, right-aligned.
rdata_o  out  DATA_W  extended load result; valid when done_o=1.
done_o  out  1  access finished (one-cycle pulse).
err_o  out  1  access failed; qualified by done_o.
misalign_o  out  1  failure cause is misalignment; qualified by done_o.
stall_o  out  1  hold datapath.
wbm_adr_o  out  ADDR_W  word-aligned address.
wbm_dat_o  out  DATA_W  lane-steered store data.
wbm_dat_i  in  DATA_W  read data.
wbm_we_o  out  1  write enable.
wbm_sel_o  out  SEL_W  byte selects.
wbm_cyc_o  out  1  cycle.
wbm_stb_o  out  1  strobe.
wbm_ack_i  in  1  acknowledge.
wbm_err_i  in  1  bus error.

Behaviour:
- Reset values: all outputs 0; state IDLE.
  - Asserting rst_i mid-access drops cyc/stb immediately and abandons the access with no done_o.
- FSM states: IDLE, BUS, DONE.
- IDLE, req_i=1:
  - Decode funct3_i and the offset off = addr_i[log2(SEL_W)-1:0]; compute size.
  - Legal and aligned: register adr/dat/sel/we; go to BUS.
  - Misaligned (off not a multiple of size): go to DONE with err_o=1 and misalign_o=1; no bus cycle.
  - Illegal funct3: go to DONE with err_o=1 and misalign_o=0; no bus cycle.
  - Illegal funct3 values:
    - loads: 111 always; 011 and 110 when DATA_W=32;
    - stores: any value >=100; 011 when DATA_W=32.
- BUS:
  - cyc/stb/we/sel/adr/dat held constant.
  - On wbm_ack_i or wbm_err_i: drop cyc/stb on the next edge; go to DONE.
  - On a load ack: capture the extracted, extended data into rdata_o.
  - wbm_err_i sets err_o; if ack and err arrive together, err wins.
- DONE:
  - done_o=1 and stall_o=0 for exactly one cycle; rdata_o/err_o/misalign_o valid.
  - Go to IDLE. rdata_o holds its value until the next load completes.
- stall_o = (IDLE & req_i) | BUS. It is combinational on req_i so the instruction stays put.
  - After DONE, the datapath advances and the next req_i is sampled in IDLE.
- Latency: minimum 3 cycles (IDLE, BUS with same-cycle ack, DONE). Errors detected in IDLE take 2 cycles.
- Lane steering:
  - wbm_sel_o = base mask << off; base masks are B=1, H=3, W=0xF, D=0xFF.
  - wbm_dat_o = wdata_i << (8*off).
  - wbm_adr_o = addr_i with its low log2(SEL_W) bits cleared.
- Load extraction: (wbm_dat_i >> 8*off), truncated to size.
  - Sign-extended for LB/LH/LW (LW only when DATA_W=64); zero-extended for LBU/LHU/LWU.
- req_i deasserting while in BUS has no effect; the access completes.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to BUS and increments each BUS cycle.
  - When the counter reaches TIMEOUT_CYC with no ack/err: drop cyc/stb, go to DONE with err_o=1 and misalign_o=0.
- Undefined: no counter; BUS waits indefinitely.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD;
  - state encoding: IDLE=2'd0, BUS=2'd1, DONE=2'd2;
  - base-mask constants.
- Sub-module lsu_align (purely combinational):
  - inputs: funct3, offset, wdata, bus rdata;
  - outputs: sel, steered wdata, extended rdata, misaligned, illegal.
- The FSM and registers stay in lsu_wb.

Test Plan:
- DATA_W=32. SB, addr=0x1003, wdata=0xAB. Expect wbm_adr_o=0x1000, sel=1000b, dat_o=0xAB000000, cyc/stb for one cycle, done_o on the third cycle.
- LH, addr=0x2002, wbm_dat_i=0x8001_xxxx, ack the first BUS cycle. Expect sel=1100b, rdata_o=0xFFFF8001. Repeat with LHU: expect 0x00008001.
- LW, addr=0x3001. Expect no cyc ever; done_o on cycle 2 with err_o=1 and misalign_o=1.
- SW, ack delayed 5 cycles. Expect stall_o high through all 6 BUS cycles and signals stable; simultaneous ack+err gives err_o=1.
- DATA_W=64. LD, addr=0x8, wbm_dat_i=0x8000_0000_0000_0001. Expect rdata_o unchanged, sel=0xFF. Illegal funct3=111 gives err_o=1 with no bus cycle.
- LSU_TIMEOUT_EN, TIMEOUT_CYC=4, no ack. Expect cyc to drop after 4 BUS cycles, then done_o with err_o=1. Separately, rst_i pulsed mid-BUS drops cyc asynchronously and produces no done_o.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM state encoding and byte-lane base masks for lsu_wb
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

endpackage

// File: rtl/lsu_wb_if.sv
// rtl/lsu_wb_if.sv - Wishbone B4 classic data port bundle with master/slave views
interface lsu_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  localparam int SEL_W = DATA_W / 8
);
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_w;
  logic [DATA_W-1:0] dat_r;
  logic              we;
  logic [SEL_W-1:0]  sel;
  logic              cyc;
  logic              stb;
  logic              ack;
  logic              err;

  modport master (output adr, dat_w, we, sel, cyc, stb, input dat_r, ack, err);
  modport slave  (input adr, dat_w, we, sel, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational funct3 decode, byte-lane steering and load extension
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int SEL_W = DATA_W / 8,
  localparam int OFF_W = $clog2(SEL_W)
) (
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] wdat,
  output logic [DATA_W-1:0] rext,
  output logic              misaligned,
  output logic              illegal
);
  logic [7:0]        base;
  logic [OFF_W-1:0]  amask;
  logic [DATA_W-1:0] shifted;

  // Store codes double as the size code held in funct3[1:0].
  always_comb begin
    base  = MASK_D;
    amask = OFF_W'(7);
    case ({1'b0, funct3[1:0]})
      F3_SB: begin base = MASK_B; amask = '0;         end
      F3_SH: begin base = MASK_H; amask = OFF_W'(1);  end
      F3_SW: begin base = MASK_W; amask = OFF_W'(3);  end
      default: ;
    endcase
  end

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    rext    = shifted;
    case (funct3)
      F3_LB:   rext = DATA_W'($signed(shifted[7:0]));
      F3_LH:   rext = DATA_W'($signed(shifted[15:0]));
      F3_LW:   rext = DATA_W'($signed(shifted[31:0]));
      F3_LBU:  rext = DATA_W'(shifted[7:0]);
      F3_LHU:  rext = DATA_W'(shifted[15:0]);
      F3_LWU:  rext = DATA_W'(shifted[31:0]);
      default: rext = shifted;
    endcase
  end

  assign sel        = SEL_W'(base) << off;
  assign wdat       = wdata << {off, 3'b000};
  assign misaligned = |(off & amask);
  assign illegal    = we ? (funct3[2] || (DATA_W == 32 && funct3 == F3_SD))
                         : (funct3 == 3'b111 || (DATA_W == 32 && (funct3 == F3_LD || funct3 == F3_LWU)));
endmodule

// File: rtl/lsu_wb.sv
// rtl/lsu_wb.sv - registered load/store unit driving a Wishbone B4 classic master port
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_wb
  import lsu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  localparam int SEL_W      = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              misalign_o,
  output logic              stall_o,
  lsu_wb_if.master          wbm
);
  localparam int OFF_W = $clog2(SEL_W);

  if (!(DATA_W == 32 || DATA_W == 64) || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("lsu_wb: unsupported DATA_W or TIMEOUT_CYC");
  end

  state_t            state;
  logic [2:0]        f3_q;
  logic [OFF_W-1:0]  off_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [SEL_W-1:0]  sel_q;
  logic              we_q;
  logic              cyc_q;
  logic              idle;
  logic [2:0]        a_f3;
  logic [OFF_W-1:0]  a_off;
  logic              a_we;
  logic [SEL_W-1:0]  a_sel;
  logic [DATA_W-1:0] a_wdat;
  logic [DATA_W-1:0] a_rext;
  logic              a_mis;
  logic              a_ill;

  // Decode the live request in IDLE; once on the bus, extract with the captured access.
  assign idle  = (state == IDLE);
  assign a_f3  = idle ? funct3_i : f3_q;
  assign a_off = idle ? addr_i[OFF_W-1:0] : off_q;
  assign a_we  = idle ? we_i : we_q;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .we(a_we), .funct3(a_f3), .off(a_off), .wdata(wdata_i), .rdata(wbm.dat_r),
    .sel(a_sel), .wdat(a_wdat), .rext(a_rext), .misaligned(a_mis), .illegal(a_ill)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      f3_q       <= '0;
      off_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      rdata_o    <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      misalign_o <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_i) begin
          f3_q  <= funct3_i;
          off_q <= addr_i[OFF_W-1:0];
          we_q  <= we_i;
          if (a_ill || a_mis) begin
            state      <= DONE;
            done_o     <= 1'b1;
            err_o      <= 1'b1;
            misalign_o <= !a_ill;
          end else begin
            state <= BUS;
            adr_q <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            dat_q <= a_wdat;
            sel_q <= a_sel;
            cyc_q <= 1'b1;
`ifdef LSU_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        BUS: begin
          if (wbm.ack || wbm.err) begin
            state      <= DONE;
            cyc_q      <= 1'b0;
            done_o     <= 1'b1;
            err_o      <= wbm.err;
            misalign_o <= 1'b0;
            if (!wbm.err && !we_q) rdata_o <= a_rext;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state      <= DONE;
            cyc_q      <= 1'b0;
            done_o     <= 1'b1;
            err_o      <= 1'b1;
            misalign_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_o   = (idle && req_i) || (state == BUS);
  assign wbm.adr   = adr_q;
  assign wbm.dat_w = dat_q;
  assign wbm.sel   = sel_q;
  assign wbm.we    = we_q;
  assign wbm.cyc   = cyc_q;
  assign wbm.stb   = cyc_q;
endmodule

// File: tb/tb_lsu_wb.sv
// tb/tb_lsu_wb.sv - directed checks of lsu_wb at DATA_W=32 and DATA_W=64
module tb_lsu_wb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        req_a, we_a, done_a, err_a, mis_a, stall_a;
  logic [2:0]  f3_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        req_b, we_b, done_b, err_b, mis_b, stall_b;
  logic [2:0]  f3_b;
  logic [31:0] addr_b;
  logic [63:0] wdata_b, rdata_b;

  lsu_wb_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
  lsu_wb_if #(.DATA_W(64), .ADDR_W(32)) bus_b ();

  lsu_wb #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we_a), .funct3_i(f3_a),
    .addr_i(addr_a), .wdata_i(wdata_a), .rdata_o(rdata_a), .done_o(done_a),
    .err_o(err_a), .misalign_o(mis_a), .stall_o(stall_a), .wbm(bus_a)
  );

  lsu_wb #(.DATA_W(64), .ADDR_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we_b), .funct3_i(f3_b),
    .addr_i(addr_b), .wdata_i(wdata_b), .rdata_o(rdata_b), .done_o(done_b),
    .err_o(err_b), .misalign_o(mis_b), .stall_o(stall_b), .wbm(bus_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    req_a = 0; we_a = 0; f3_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; f3_b = 0; addr_b = 0; wdata_b = 0;
    bus_a.dat_r = '0; bus_a.ack = 0; bus_a.err = 0;
    bus_b.dat_r = '0; bus_b.ack = 0; bus_b.err = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_cyc", bus_a.cyc, 0);
    chk("rst_done", done_a, 0);
    chk("rst_stall", stall_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_sel", bus_a.sel, 0);
    rst = 0;

    // SB to the top byte lane, acked in the first BUS cycle
    we_a = 1; f3_a = 3'b000; addr_a = 32'h1003; wdata_a = 32'hAB; req_a = 1;
    #1 chk("sb_stall_idle", stall_a, 1);
    @(negedge clk);
    chk("sb_cyc", bus_a.cyc, 1);
    chk("sb_stb", bus_a.stb, 1);
    chk("sb_we", bus_a.we, 1);
    chk("sb_adr", bus_a.adr, 32'h1000);
    chk("sb_sel", bus_a.sel, 4'b1000);
    chk("sb_dat", bus_a.dat_w, 32'hAB00_0000);
    bus_a.ack = 1;
    @(negedge clk);
    bus_a.ack = 0;
    chk("sb_done", done_a, 1);
    chk("sb_err", err_a, 0);
    chk("sb_cyc_drop", bus_a.cyc, 0);
    chk("sb_stall_done", stall_a, 0);
    req_a = 0;
    @(negedge clk);
    chk("sb_done_pulse", done_a, 0);

    // LH then LHU from the upper half
    we_a = 0; f3_a = 3'b001; addr_a = 32'h2002; bus_a.dat_r = 32'h8001_1234; req_a = 1;
    @(negedge clk);
    chk("lh_sel", bus_a.sel, 4'b1100);
    chk("lh_we", bus_a.we, 0);
    chk("lh_adr", bus_a.adr, 32'h2000);
    bus_a.ack = 1;
    @(negedge clk);
    bus_a.ack = 0;
    chk("lh_done", done_a, 1);
    chk("lh_rdata", rdata_a, 32'hFFFF_8001);
    req_a = 0;
    @(negedge clk);
    f3_a = 3'b101; req_a = 1;
    @(negedge clk);
    bus_a.ack = 1;
    @(negedge clk);
    bus_a.ack = 0;
    chk("lhu_done", done_a, 1);
    chk("lhu_rdata", rdata_a, 32'h0000_8001);
    req_a = 0;
    @(negedge clk);

    // Misaligned LW: no bus cycle, result in two cycles
    f3_a = 3'b010; addr_a = 32'h3001; req_a = 1;
    @(negedge clk);
    chk("lw_mis_cyc", bus_a.cyc, 0);
    chk("lw_mis_done", done_a, 1);
    chk("lw_mis_err", err_a, 1);
    chk("lw_mis_flag", mis_a, 1);
    chk("lw_mis_rdata_hold", rdata_a, 32'h0000_8001);
    req_a = 0;
    @(negedge clk);
    chk("lw_mis_done_pulse", done_a, 0);

    // Store funct3=100 is illegal
    we_a = 1; f3_a = 3'b100; addr_a = 32'h10; req_a = 1;
    @(negedge clk);
    chk("sill_cyc", bus_a.cyc, 0);
    chk("sill_done", done_a, 1);
    chk("sill_err", err_a, 1);
    chk("sill_mis", mis_a, 0);
    req_a = 0;
    @(negedge clk);

    // 64-bit SW at offset 4, ack+err together after five wait cycles
    we_b = 1; f3_b = 3'b010; addr_b = 32'h14; wdata_b = 64'h1122_3344; req_b = 1;
    @(negedge clk);
    chk("sw64_adr", bus_b.adr, 32'h10);
    for (int i = 0; i < 6; i++) begin
      chk("sw64_stall", stall_b, 1);
      chk("sw64_cyc", bus_b.cyc, 1);
      chk("sw64_sel", bus_b.sel, 8'hF0);
      chk("sw64_dat", bus_b.dat_w, 64'h1122_3344_0000_0000);
      if (i == 5) begin
        bus_b.ack = 1; bus_b.err = 1;
      end
      @(negedge clk);
    end
    bus_b.ack = 0; bus_b.err = 0;
    chk("sw64_done", done_b, 1);
    chk("sw64_err", err_b, 1);
    chk("sw64_mis", mis_b, 0);
    chk("sw64_cyc_drop", bus_b.cyc, 0);
    req_b = 0;
    @(negedge clk);

    // 64-bit LD passes the word through unchanged
    we_b = 0; f3_b = 3'b011; addr_b = 32'h8; bus_b.dat_r = 64'h8000_0000_0000_0001; req_b = 1;
    @(negedge clk);
    chk("ld64_sel", bus_b.sel, 8'hFF);
    chk("ld64_adr", bus_b.adr, 32'h8);
    bus_b.ack = 1;
    @(negedge clk);
    bus_b.ack = 0;
    chk("ld64_done", done_b, 1);
    chk("ld64_err", err_b, 0);
    chk("ld64_rdata", rdata_b, 64'h8000_0000_0000_0001);
    req_b = 0;
    @(negedge clk);

    // funct3=111 load is illegal at any width
    f3_b = 3'b111; addr_b = 32'h20; req_b = 1;
    @(negedge clk);
    chk("ill64_cyc", bus_b.cyc, 0);
    chk("ill64_done", done_b, 1);
    chk("ill64_err", err_b, 1);
    chk("ill64_mis", mis_b, 0);
    req_b = 0;
    @(negedge clk);

    // Unacknowledged LW: watchdog fires after four BUS cycles, else the bus just waits
    we_a = 0; f3_a = 3'b010; addr_a = 32'h5000; req_a = 1;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_cyc_held", bus_a.cyc, 1);
    end
    @(negedge clk);
    chk("to_cyc_drop", bus_a.cyc, 0);
    chk("to_done", done_a, 1);
    chk("to_err", err_a, 1);
    chk("to_mis", mis_a, 0);
`else
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("wait_cyc_held", bus_a.cyc, 1);
    end
    bus_a.ack = 1;
    @(negedge clk);
    bus_a.ack = 0;
    chk("wait_done", done_a, 1);
    chk("wait_err", err_a, 0);
`endif
    req_a = 0;
    @(negedge clk);

    // Reset mid-BUS drops cyc immediately and never reports completion
    we_a = 1; f3_a = 3'b010; addr_a = 32'h6000; req_a = 1;
    @(negedge clk);
    chk("rstbus_cyc_before", bus_a.cyc, 1);
    #2 rst = 1;
    #1 chk("rstbus_cyc_async", bus_a.cyc, 0);
    req_a = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstbus_no_done", done_a, 0);
    end
    chk("rstbus_rdata", rdata_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
